pipeline_stall_ctrl: RTL and testbench
======================================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, instruction word inserted as a bubble (addi x0,x0,0).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port HDUStall  input  1  load-use stall request from hazard detection.
REQ-007 SHALL have port branch_taken_ex  input  1  taken branch/jump resolved in EX (PC redirect this cycle).
REQ-008 SHALL have port dmem_wait  input  1  data memory not ready; freeze whole pipeline.
REQ-009 SHALL have ports pc_if, pc4_if  input  XLEN  PC and PC+4 of the instruction being fetched.
REQ-010 SHALL have port inst_if  input  32  fetched instruction word.
REQ-011 SHALL have port pc_en  output  1  PC register write enable.
REQ-012 SHALL have ports pc_de, pc4_de  output  XLEN  registered IF/ID PC and PC+4.
REQ-013 SHALL have port inst_de  output  32  registered IF/ID instruction.
REQ-014 SHALL have port valid_de  output  1  IF/ID holds a real instruction.
REQ-015 SHALL have port flush_ex  output  1  ID/EX loads a bubble at the next edge.
REQ-016 SHALL have port freeze  output  1  hold ID/EX, EX/ME and ME/WB registers this cycle.
REQ-017 SHALL have port ctrl_state  output  2  current state encoding.

Function
REQ-018 SHALL evaluate requests each cycle in strict priority: dmem_wait > branch_taken_ex > HDUStall > normal.
REQ-019 On dmem_wait=1, SHALL drive freeze=1, pc_en=0, flush_ex=0, and hold the IF/ID register.
REQ-020 On branch_taken_ex=1 without dmem_wait, SHALL drive pc_en=1, flush_ex=1, load IF/ID with inst_de=NOP_INST and valid_de=0, and keep pc_de/pc4_de unchanged.
REQ-021 On HDUStall=1 with no higher-priority request, SHALL drive pc_en=0, flush_ex=1, and hold IF/ID, giving exactly one bubble per asserted cycle.
REQ-022 Otherwise, SHALL drive pc_en=1, flush_ex=0, freeze=0, and load IF/ID from pc_if/pc4_if/inst_if with valid_de=1.
REQ-023 pc_en, flush_ex and freeze SHALL be combinational with zero latency; IF/ID outputs SHALL update at the next rising edge.
REQ-024 SHALL use the states RUN=0, LOADUSE=1, REDIRECT=2 and FREEZE=3; the next state SHALL encode the action taken this cycle (normal->RUN, HDUStall->LOADUSE, branch->REDIRECT, dmem_wait->FREEZE).
REQ-025 A branch_taken_ex and HDUStall arriving together SHALL produce the redirect action only, because the ID instruction is on the wrong path.
REQ-026 A dmem_wait arriving together with branch_taken_ex SHALL freeze only, with the redirect taken in the first non-wait cycle, provided branch_taken_ex is still asserted.

Reset
REQ-027 While rst=1, SHALL drive pc_en=0, flush_ex=1 and freeze=0.
REQ-028 At a reset edge, SHALL set inst_de=NOP_INST, pc_de=0, pc4_de=0, valid_de=0 and ctrl_state=RUN, overriding all other inputs.
REQ-029 A reset asserted mid-stall or mid-freeze SHALL abandon that action with no residual bubble.

Configuration
REQ-030 Macro STALL_PERF_COUNTERS_EN SHALL control the performance counters.
REQ-031 With STALL_PERF_COUNTERS_EN defined, SHALL add 32-bit outputs loaduse_cnt, redirect_cnt and freeze_cnt, each incrementing once per cycle of its action, wrapping from 2^32-1 to 0, and cleared by reset.
REQ-032 Without STALL_PERF_COUNTERS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 The state enum, NOP_INST and the XLEN default SHALL reside in the shared core package.
REQ-034 The IF/ID register SHALL be one sub-module, if_id_reg, with inputs en and flush; the control FSM SHALL remain in pipeline_stall_ctrl.

Verification
REQ-035 Reset, then inst_if=0x00500093, pc_if=0x100 with no requests -> next cycle inst_de=0x00500093, pc_de=0x100, valid_de=1, pc_en=1.
REQ-036 HDUStall=1 for one cycle with inst_de=0x002081B3 -> pc_en=0 and flush_ex=1 that cycle; inst_de is unchanged after the edge; ctrl_state=LOADUSE; normal flow resumes the following cycle.
REQ-037 branch_taken_ex=1 and HDUStall=1 in the same cycle -> pc_en=1, flush_ex=1; next cycle inst_de=0x00000013, valid_de=0, ctrl_state=REDIRECT.
REQ-038 dmem_wait=1 for 3 cycles with branch_taken_ex held -> freeze=1 and pc_en=0 for 3 cycles with IF/ID stable; redirect occurs on the 4th cycle; freeze_cnt=3 (macro defined).
REQ-039 rst asserted during the second dmem_wait cycle -> at the next edge valid_de=0, inst_de=0x00000013, ctrl_state=RUN, and all counters=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared core definitions for the pipeline stall controller: width defaults,
// bubble instruction, controller state encoding and the per-cycle control bundle.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned CORE_XLEN     = 32;
  localparam logic [31:0] CORE_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  // Order of the optional performance counters (loaduse, redirect, freeze).
  localparam int unsigned NUM_PERF_CNT = 3;
  localparam int unsigned PERF_LOADUSE  = 0;
  localparam int unsigned PERF_REDIRECT = 1;
  localparam int unsigned PERF_FREEZE   = 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOADUSE  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FREEZE   = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic flush_ex;
    logic freeze;
    logic ifid_en;
    logic ifid_flush;
  } stall_ctrl_t;

  // Action of a cycle given the raw requests; reset overrides everything.
  function automatic ctrl_state_e action_of(input logic rst, input logic dmem_wait,
                                            input logic branch_taken, input logic hdu_stall);
    ctrl_state_e act;
    act = ST_RUN;
    if (rst)               act = ST_RUN;
    else if (dmem_wait)    act = ST_FREEZE;
    else if (branch_taken) act = ST_REDIRECT;
    else if (hdu_stall)    act = ST_LOADUSE;
    return act;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if_id_reg.sv
// IF/ID pipeline register: reset > flush (bubble, PC kept) > load > hold.
module if_id_reg
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = CORE_XLEN,
  parameter logic [31:0] NOP_INST = CORE_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc4_in,
  input  logic [31:0]     inst_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc4_out,
  output logic [31:0]     inst_out,
  output logic            valid_out
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [31:0]     inst_q, inst_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush) begin
      // A redirected fetch slot becomes a bubble; its PC fields are left alone.
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (en) begin
      pc_d    = pc_in;
      pc4_d   = pc4_in;
      inst_d  = inst_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      pc4_q   <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign pc4_out   = pc4_q;
  assign inst_out  = inst_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush/freeze controller with the IF/ID register.
// Optional macro STALL_PERF_COUNTERS_EN adds loaduse/redirect/freeze cycle counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = CORE_XLEN,
  parameter logic [31:0] NOP_INST = CORE_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            HDUStall,
  input  logic            branch_taken_ex,
  input  logic            dmem_wait,
  input  logic [XLEN-1:0] pc_if,
  input  logic [XLEN-1:0] pc4_if,
  input  logic [31:0]     inst_if,
  output logic            pc_en,
  output logic [XLEN-1:0] pc_de,
  output logic [XLEN-1:0] pc4_de,
  output logic [31:0]     inst_de,
  output logic            valid_de,
  output logic            flush_ex,
  output logic            freeze,
  output logic [1:0]      ctrl_state
`ifdef STALL_PERF_COUNTERS_EN
  ,
  output logic [31:0]     loaduse_cnt,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     freeze_cnt
`endif
);

  ctrl_state_e state_q, state_d;
  stall_ctrl_t ctrl;

  // The next state simply records which action this cycle performed.
  always_comb begin
    state_d = action_of(rst, dmem_wait, branch_taken_ex, HDUStall);
    ctrl    = '0;
    if (rst) begin
      ctrl.flush_ex = 1'b1;
    end else begin
      unique case (state_d)
        ST_FREEZE: begin
          ctrl.freeze = 1'b1;
        end
        ST_REDIRECT: begin
          ctrl.pc_en      = 1'b1;
          ctrl.flush_ex   = 1'b1;
          ctrl.ifid_flush = 1'b1;
        end
        ST_LOADUSE: begin
          ctrl.flush_ex = 1'b1;
        end
        default: begin
          ctrl.pc_en   = 1'b1;
          ctrl.ifid_en = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  assign pc_en      = ctrl.pc_en;
  assign flush_ex   = ctrl.flush_ex;
  assign freeze     = ctrl.freeze;
  assign ctrl_state = state_q;

  if_id_reg #(
    .XLEN     (XLEN),
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .en        (ctrl.ifid_en),
    .flush     (ctrl.ifid_flush),
    .pc_in     (pc_if),
    .pc4_in    (pc4_if),
    .inst_in   (inst_if),
    .pc_out    (pc_de),
    .pc4_out   (pc4_de),
    .inst_out  (inst_de),
    .valid_out (valid_de)
  );

`ifdef STALL_PERF_COUNTERS_EN
  logic [NUM_PERF_CNT-1:0] cnt_inc;

  always_comb begin
    cnt_inc                = '0;
    cnt_inc[PERF_LOADUSE]  = (state_d == ST_LOADUSE);
    cnt_inc[PERF_REDIRECT] = (state_d == ST_REDIRECT);
    cnt_inc[PERF_FREEZE]   = (state_d == ST_FREEZE);
  end

  genvar gi;
  for (gi = 0; gi < NUM_PERF_CNT; gi++) begin : g_cnt
    logic [31:0] cnt_q, cnt_d;

    // Plain modulo-2^32 increment: wraps from all-ones to zero.
    always_comb cnt_d = cnt_q + {31'd0, cnt_inc[gi]};

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
  end

  assign loaduse_cnt  = g_cnt[PERF_LOADUSE].cnt_q;
  assign redirect_cnt = g_cnt[PERF_REDIRECT].cnt_q;
  assign freeze_cnt   = g_cnt[PERF_FREEZE].cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Table-driven bench for pipeline_stall_ctrl plus hand sequences for
// freeze-then-redirect and reset in the middle of a freeze.
module tb_pipeline_stall_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, HDUStall, branch_taken_ex, dmem_wait;
  logic [31:0] pc_if, pc4_if, inst_if;
  logic        pc_en, valid_de, flush_ex, freeze;
  logic [31:0] pc_de, pc4_de, inst_de;
  logic [1:0]  ctrl_state;
`ifdef STALL_PERF_COUNTERS_EN
  logic [31:0] loaduse_cnt, redirect_cnt, freeze_cnt;
  int unsigned exp_lu, exp_rd, exp_fz;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .HDUStall        (HDUStall),
    .branch_taken_ex (branch_taken_ex),
    .dmem_wait       (dmem_wait),
    .pc_if           (pc_if),
    .pc4_if          (pc4_if),
    .inst_if         (inst_if),
    .pc_en           (pc_en),
    .pc_de           (pc_de),
    .pc4_de          (pc4_de),
    .inst_de         (inst_de),
    .valid_de        (valid_de),
    .flush_ex        (flush_ex),
    .freeze          (freeze),
    .ctrl_state      (ctrl_state)
`ifdef STALL_PERF_COUNTERS_EN
    ,
    .loaduse_cnt     (loaduse_cnt),
    .redirect_cnt    (redirect_cnt),
    .freeze_cnt      (freeze_cnt)
`endif
  );

  typedef struct {
    logic        rst, hdu, br, dmem;
    logic [31:0] pc, inst;
    logic        e_pc_en, e_flush, e_freeze;
    logic [31:0] e_inst, e_pc;
    logic        e_valid;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input string tag, input vec_t v);
    logic [31:0] e_pc4;
    rst             = v.rst;
    HDUStall        = v.hdu;
    branch_taken_ex = v.br;
    dmem_wait       = v.dmem;
    pc_if           = v.pc;
    pc4_if          = v.pc + 32'd4;
    inst_if         = v.inst;
    #1;
    chk({tag, ".pc_en"},    {31'd0, pc_en},    {31'd0, v.e_pc_en});
    chk({tag, ".flush_ex"}, {31'd0, flush_ex}, {31'd0, v.e_flush});
    chk({tag, ".freeze"},   {31'd0, freeze},   {31'd0, v.e_freeze});
`ifdef STALL_PERF_COUNTERS_EN
    if (v.rst) begin
      exp_lu = 0; exp_rd = 0; exp_fz = 0;
    end else if (v.dmem) exp_fz++;
    else if (v.br)       exp_rd++;
    else if (v.hdu)      exp_lu++;
`endif
    @(posedge clk);
    #1;
    e_pc4 = (v.e_pc == 32'd0) ? 32'd0 : v.e_pc + 32'd4;
    chk({tag, ".inst_de"},    inst_de,                v.e_inst);
    chk({tag, ".pc_de"},      pc_de,                  v.e_pc);
    chk({tag, ".pc4_de"},     pc4_de,                 e_pc4);
    chk({tag, ".valid_de"},   {31'd0, valid_de},      {31'd0, v.e_valid});
    chk({tag, ".ctrl_state"}, {30'd0, ctrl_state},    {30'd0, v.e_state});
`ifdef STALL_PERF_COUNTERS_EN
    chk({tag, ".loaduse_cnt"},  loaduse_cnt,  exp_lu);
    chk({tag, ".redirect_cnt"}, redirect_cnt, exp_rd);
    chk({tag, ".freeze_cnt"},   freeze_cnt,   exp_fz);
`endif
  endtask

  function automatic vec_t mk(input logic r, input logic h, input logic b, input logic d,
                              input logic [31:0] pc, input logic [31:0] inst,
                              input logic epe, input logic efl, input logic efr,
                              input logic [31:0] einst, input logic [31:0] epc,
                              input logic ev, input logic [1:0] est);
    vec_t v;
    v.rst = r; v.hdu = h; v.br = b; v.dmem = d; v.pc = pc; v.inst = inst;
    v.e_pc_en = epe; v.e_flush = efl; v.e_freeze = efr;
    v.e_inst = einst; v.e_pc = epc; v.e_valid = ev; v.e_state = est;
    return v;
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; HDUStall = 1'b0; branch_taken_ex = 1'b0; dmem_wait = 1'b0;
    pc_if = '0; pc4_if = '0; inst_if = '0;
`ifdef STALL_PERF_COUNTERS_EN
    exp_lu = 0; exp_rd = 0; exp_fz = 0;
`endif

    //             rst   hdu   br    dmem  pc          inst          pe    fl    fr    e_inst        e_pc        v     state
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,        1'b0, 1'b1, 1'b0, NOP,          32'h0,      1'b0, 2'd0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h100,    32'h00500093, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h100,    1'b1, 2'd0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h104,    32'h002081B3, 1'b1, 1'b0, 1'b0, 32'h002081B3, 32'h104,    1'b1, 2'd0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h108,    32'h00108133, 1'b0, 1'b1, 1'b0, 32'h002081B3, 32'h104,    1'b1, 2'd1);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h108,    32'h00108133, 1'b1, 1'b0, 1'b0, 32'h00108133, 32'h108,    1'b1, 2'd0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h10C,    32'hAAAA0001, 1'b1, 1'b1, 1'b0, NOP,          32'h108,    1'b0, 2'd2);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h200,    32'h00000513, 1'b1, 1'b0, 1'b0, 32'h00000513, 32'h200,    1'b1, 2'd0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h204,    32'h11111111, 1'b0, 1'b0, 1'b1, 32'h00000513, 32'h200,    1'b1, 2'd3);
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h204,    32'h11111111, 1'b0, 1'b0, 1'b1, 32'h00000513, 32'h200,    1'b1, 2'd3);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h204,    32'h11111111, 1'b1, 1'b1, 1'b0, NOP,          32'h200,    1'b0, 2'd2);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h300,    32'h22222222, 1'b0, 1'b1, 1'b0, NOP,          32'h200,    1'b0, 2'd1);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h300,    32'h12345678, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h300,    1'b1, 2'd0);

    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
      $display("vec %0d: rst=%0b hdu=%0b br=%0b dmem=%0b -> inst_de=%08h state=%0d",
               i, vecs[i].rst, vecs[i].hdu, vecs[i].br, vecs[i].dmem, inst_de, ctrl_state);
    end

    // Freeze for three cycles with a branch pending, then redirect.
    step("frz.rst", mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, NOP, 32'h0, 1'b0, 2'd0));
    step("frz.load", mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 32'h00500093, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h400, 1'b1, 2'd0));
    for (int c = 0; c < 3; c++) begin
      step($sformatf("frz.wait%0d", c),
           mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h404, 32'h0badc0de, 1'b0, 1'b0, 1'b1, 32'h00500093, 32'h400, 1'b1, 2'd3));
      $display("freeze cycle %0d: freeze=%0b pc_en=%0b inst_de=%08h", c, freeze, pc_en, inst_de);
    end
    step("frz.redirect", mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h404, 32'h0badc0de, 1'b1, 1'b1, 1'b0, NOP, 32'h400, 1'b0, 2'd2));
`ifdef STALL_PERF_COUNTERS_EN
    chk("frz.freeze_cnt_is_3", freeze_cnt, 32'd3);
    $display("freeze sequence: freeze_cnt=%0d redirect_cnt=%0d", freeze_cnt, redirect_cnt);
`endif

    // Reset during the second freeze cycle, then resume without residue.
    step("rstw.load", mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h00A00113, 1'b1, 1'b0, 1'b0, 32'h00A00113, 32'h500, 1'b1, 2'd0));
    step("rstw.wait1", mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h504, 32'h33333333, 1'b0, 1'b0, 1'b1, 32'h00A00113, 32'h500, 1'b1, 2'd3));
    step("rstw.wait2rst", mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h504, 32'h33333333, 1'b0, 1'b1, 1'b0, NOP, 32'h0, 1'b0, 2'd0));
`ifdef STALL_PERF_COUNTERS_EN
    chk("rstw.freeze_cnt_zero", freeze_cnt, 32'd0);
`endif
    step("rstw.resume", mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h504, 32'h00000093, 1'b1, 1'b0, 1'b0, 32'h00000093, 32'h504, 1'b1, 2'd0));
    $display("reset-in-freeze sequence: inst_de=%08h valid_de=%0b state=%0d", inst_de, valid_de, ctrl_state);

    // Reset asserted while a load-use stall is requested.
    step("rsth.stall", mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h44444444, 1'b0, 1'b1, 1'b0, NOP, 32'h0, 1'b0, 2'd0));
    step("rsth.resume", mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h00500093, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h600, 1'b1, 2'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
